// File: rtl/seq_detect_1011_pkg.sv
// rtl/seq_detect_1011_pkg.sv - state encoding and pattern constants for the 1011 detector
package seq_detect_1011_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detect_1011_if.sv
// rtl/seq_detect_1011_if.sv - serial input and match/count outputs of the 1011 detector
interface seq_detect_1011_if #(parameter int CNT_W = 8);
  logic             clr;
  logic             din_valid;
  logic             din;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output clr, din_valid, din, input match, match_cnt, cnt_sat);
  modport slave  (input clr, din_valid, din, output match, match_cnt, cnt_sat);
endinterface

// File: rtl/seq_detect_1011_dff_ar.sv
// rtl/seq_detect_1011_dff_ar.sv - 1-bit D flip-flop, async active-high reset, load enable
module seq_detect_1011_dff_ar (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= 1'b0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/seq_detect_1011.sv
// rtl/seq_detect_1011.sv - overlapping 1011 detector with saturating match counter
// Next-state, match and counter logic are gate primitives; only the flops are behavioural.
module seq_detect_1011
  import seq_detect_1011_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_detect_1011_if.slave   bus
);

  logic [STATE_W-1:0] st, st_n, st_d;
  logic [STATE_W-1:0] nv, hv, va, vb, mx;
  logic clr_n, v_n, d_n;
  logic a00, b01, c10;
  logic is0, is1, is2, is3, is4;
  logic o01, o24, o13, g0, g1, t1a, t1b;
  logic acc, match_d, match_q;
  logic top_n, inc_ok, cnt_en;
  logic sat_set, sat_h, sat_d, sat_q;
  logic [CNT_W:0]   carry;
  logic [CNT_W-1:0] sum, cnt_d, cnt_q, sum_all;

  not (clr_n, bus.clr);
  not (v_n, bus.din_valid);
  not (d_n, bus.din);
  not (st_n[0], st[0]);
  not (st_n[1], st[1]);
  not (st_n[2], st[2]);

  // One-hot decode of the legal states; encodings 5..7 decode to nothing and fall to S0.
  nor (a00, st[2], st[1]);
  and (is0, a00, st_n[0]);
  and (is1, a00, st[0]);
  and (b01, st_n[2], st[1]);
  and (is2, b01, st_n[0]);
  and (is3, b01, st[0]);
  nor (c10, st[1], st[0]);
  and (is4, st[2], c10);

  // Next state for an accepted bit
  or  (o01, is0, is1);
  or  (o24, is2, is4);
  or  (g0, o01, o24);
  and (nv[0], bus.din, g0);
  or  (o13, is1, is3);
  or  (g1, o13, is4);
  and (t1a, d_n, g1);
  and (t1b, bus.din, is2);
  or  (nv[1], t1a, t1b);
  and (nv[2], bus.din, is3);

  // Hold value for an idle cycle
  assign hv[0] = o13;
  or  (hv[1], is2, is3);
  assign hv[2] = is4;

  genvar i;
  generate
    for (i = 0; i < STATE_W; i++) begin : g_state
      and (va[i], bus.din_valid, nv[i]);
      and (vb[i], v_n, hv[i]);
      or  (mx[i], va[i], vb[i]);
      and (st_d[i], mx[i], clr_n);
      seq_detect_1011_dff_ar u_st (
        .clk (clk), .rst (rst), .en (1'b1), .d (st_d[i]), .q (st[i])
      );
    end
  endgenerate

  // acc: an accepted bit drives S3 -> S4, i.e. 1011 just completed
  and (acc, bus.din_valid, nv[2]);
  and (match_d, acc, clr_n);

  seq_detect_1011_dff_ar u_match (
    .clk (clk), .rst (rst), .en (1'b1), .d (match_d), .q (match_q)
  );

  // Half-adder ripple with carry-in 1; carry out of the top marks an all-ones count.
  assign carry[0] = 1'b1;
  generate
    for (i = 0; i < CNT_W; i++) begin : g_cnt
      logic xo, xn;
      and  (carry[i+1], cnt_q[i], carry[i]);
      or   (xo, cnt_q[i], carry[i]);
      nand (xn, cnt_q[i], carry[i]);
      and  (sum[i], xo, xn);
      and  (cnt_d[i], sum[i], clr_n);
      if (i == 0) begin : g_all0
        assign sum_all[0] = sum[0];
      end else begin : g_alln
        and (sum_all[i], sum_all[i-1], sum[i]);
      end
      seq_detect_1011_dff_ar u_cnt (
        .clk (clk), .rst (rst), .en (cnt_en), .d (cnt_d[i]), .q (cnt_q[i])
      );
    end
  endgenerate

  not (top_n, carry[CNT_W]);
  and (inc_ok, acc, top_n);
  or  (cnt_en, inc_ok, bus.clr);

  and (sat_set, inc_ok, sum_all[CNT_W-1]);
  or  (sat_h, sat_q, sat_set);
  and (sat_d, sat_h, clr_n);

  seq_detect_1011_dff_ar u_sat (
    .clk (clk), .rst (rst), .en (1'b1), .d (sat_d), .q (sat_q)
  );

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// tb/tb_seq_detect_1011.sv - bench for seq_detect_1011 at CNT_W=8 and CNT_W=2
module tb_seq_detect_1011;
  import seq_detect_1011_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;

  int total = 0;
  int bad = 0;

  logic [3:0] hist = 4'd0;
  int  hlen = 0;
  bit  em = 1'b0;
  int  ec8 = 0;
  int  ec2 = 0;
  bit  es8 = 1'b0;
  bit  es2 = 1'b0;

  seq_detect_1011_if #(.CNT_W(8)) bus8 ();
  seq_detect_1011_if #(.CNT_W(2)) bus2 ();

  assign bus8.clr = clr;
  assign bus8.din_valid = din_valid;
  assign bus8.din = din;
  assign bus2.clr = clr;
  assign bus2.din_valid = din_valid;
  assign bus2.din = din;

  seq_detect_1011 #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  seq_detect_1011 #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = 4'd0; hlen = 0; em = 1'b0;
    ec8 = 0; ec2 = 0; es8 = 1'b0; es2 = 1'b0;
  endtask

  // A match is the last four accepted bits since reset/clr spelling the pattern.
  task automatic model_update(input bit v, input bit d, input bit c);
    if (c) begin
      model_reset();
    end else if (v) begin
      hist = {hist[2:0], d};
      if (hlen < 4) hlen++;
      if (hlen >= 4 && hist == PATTERN) begin
        em  = 1'b1;
        ec8 = (ec8 == 255) ? 255 : ec8 + 1;
        ec2 = (ec2 == 3) ? 3 : ec2 + 1;
        es8 = (ec8 == 255);
        es2 = (ec2 == 3);
      end else begin
        em = 1'b0;
      end
    end else begin
      em = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    check("match8", int'(bus8.match), int'(em));
    check("cnt8", int'(bus8.match_cnt), ec8);
    check("sat8", int'(bus8.cnt_sat), int'(es8));
    check("match2", int'(bus2.match), int'(em));
    check("cnt2", int'(bus2.match_cnt), ec2);
    check("sat2", int'(bus2.cnt_sat), int'(es2));
  end

  task automatic step(input bit v, input bit d, input bit c);
    din_valid = v; din = d; clr = c;
    @(posedge clk);
    #1;
    model_update(v, d, c);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_match", int'(bus8.match), 0);
    check("rst_cnt", int'(bus8.match_cnt), 0);
    check("rst_sat2", int'(bus2.cnt_sat), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int k = n - 1; k >= 0; k--) step(1'b1, b[k], 1'b0);
  endtask

  initial begin
    logic [12:0] sat_bits;
    int mi;
    int exp_c2 [4];
    int exp_s2 [4];

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_match", int'(bus8.match), 0);
    check("reset_cnt", int'(bus8.match_cnt), 0);

    // basic and overlap: 1,0,1,1,0,1,1
    feed(16'b1011, 4);
    check("basic_m1", int'(bus8.match), 1);
    check("basic_c1", int'(bus8.match_cnt), 1);
    step(1'b1, 1'b0, 1'b0);
    check("basic_gap", int'(bus8.match), 0);
    feed(16'b11, 2);
    check("overlap_m2", int'(bus8.match), 1);
    check("overlap_c2", int'(bus8.match_cnt), 2);

    // reset mid-stream after 1,0,1
    feed(16'b101, 3);
    async_reset();
    step(1'b1, 1'b1, 1'b0);
    check("post_rst_nomatch", int'(bus8.match), 0);
    feed(16'b011, 3);
    check("post_rst_match", int'(bus8.match), 1);
    check("post_rst_cnt", int'(bus8.match_cnt), 1);

    // valid gaps
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("gap_nomatch", int'(bus8.match), 0);
    step(1'b1, 1'b1, 1'b0);
    check("gap_match", int'(bus8.match), 1);
    check("gap_cnt", int'(bus8.match_cnt), 1);

    // near misses
    step(1'b0, 1'b0, 1'b1);
    feed(16'b111001011, 9);
    check("near_match", int'(bus8.match), 1);
    check("near_cnt", int'(bus8.match_cnt), 1);
    step(1'b0, 1'b0, 1'b1);
    feed(16'b10011, 5);
    check("near_zero", int'(bus8.match_cnt), 0);

    // saturation on the 2-bit counter
    step(1'b0, 1'b0, 1'b1);
    sat_bits = 13'b1011011011011;
    exp_c2 = '{1, 2, 3, 3};
    exp_s2 = '{0, 0, 1, 1};
    mi = 0;
    for (int k = 12; k >= 0; k--) begin
      step(1'b1, sat_bits[k], 1'b0);
      if (k == 9 || k == 6 || k == 3 || k == 0) begin
        check("sat_match", int'(bus2.match), 1);
        check("sat_cnt2", int'(bus2.match_cnt), exp_c2[mi]);
        check("sat_flag2", int'(bus2.cnt_sat), exp_s2[mi]);
        mi++;
      end
    end
    check("sat_cnt8", int'(bus8.match_cnt), 4);

    // clr beats a completing bit
    feed(16'b101, 3);
    step(1'b1, 1'b1, 1'b1);
    check("clr_match", int'(bus8.match), 0);
    check("clr_cnt", int'(bus8.match_cnt), 0);
    check("clr_sat2", int'(bus2.cnt_sat), 0);
    feed(16'b1011, 4);
    check("clr_after", int'(bus8.match_cnt), 1);

    // 8-bit saturation via overlapping matches
    step(1'b0, 1'b0, 1'b1);
    feed(16'b1011, 4);
    for (int k = 2; k <= 260; k++) begin
      feed(16'b011, 3);
      if (k == 254) begin
        check("c8_254", int'(bus8.match_cnt), 254);
        check("s8_254", int'(bus8.cnt_sat), 0);
      end
    end
    check("c8_full", int'(bus8.match_cnt), 255);
    check("s8_full", int'(bus8.cnt_sat), 1);
    check("m8_full", int'(bus8.match), 1);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) == 0)
        async_reset();
      else
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_1011.md
Name: seq_detect_1011

Overview:
- Serial pattern detector for the 1011 bit sequence, with a saturating match counter.
- Sequential stage built directly on top of the team's gate-primitive library (AND2/OR2/NAND2/NOR2/INV).
- Next-state and output logic are structural instances of those primitives.
- Consumes one serial bit per qualified clock; produces a one-cycle match pulse and a running match count for downstream display or checking logic.

Parameters:
- CNT_W, 8, width of the match counter; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous clear of FSM state, counter and saturation flag.
- din_valid  input  1  qualifies din for the current cycle.
- din  input  1  serial data bit, MSB-first order of the pattern.
- match  output  1  registered pulse: 1011 just completed.
- match_cnt  output  CNT_W  number of matches since reset/clr, saturating.
- cnt_sat  output  1  high once match_cnt has reached all-ones.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- On rst (any time, including mid-sequence), the following take effect immediately and hold while rst is high:
  - state = S0
  - match = 0
  - match_cnt = 0
  - cnt_sat = 0
- FSM, 5 states, binary encoded 3 bits:
  - S0 = idle
  - S1 = "1"
  - S2 = "10"
  - S3 = "101"
  - S4 = "1011"
- Transitions occur only when din_valid = 1:
  - S0: din=1 -> S1; din=0 -> S0.
  - S1: 1 -> S1; 0 -> S2.
  - S2: 1 -> S3; 0 -> S0.
  - S3: 1 -> S4; 0 -> S2.
  - S4: 1 -> S1; 0 -> S2. Overlapping detection: the trailing "1" is reused, and "10" continues from it.
- din_valid = 0: state holds, match = 0 next cycle, counter holds.
- Unused encodings 5..7 return to S0 on the next clock regardless of din_valid.
- match:
  - Registered; asserted in the cycle after the clock edge where din_valid=1 and next state is S4.
  - Latency is exactly 1 cycle from the accepting edge; width is exactly 1 cycle per match.
- match_cnt:
  - Increments by 1 on the same edge that sets match.
  - Wraps never; holds at 2^CNT_W-1.
  - cnt_sat goes high on the edge the count reaches all-ones and stays high until rst or clr.
- clr:
  - Synchronous; on the next edge forces state = S0, match = 0, match_cnt = 0, cnt_sat = 0.
  - clr has priority over din_valid in the same cycle; that bit is discarded.
- Simultaneous match completion and saturation: count stays all-ones, match still pulses, cnt_sat remains 1.
- Combinational next-state and output decode is built only from the primitive gates. Counter increment is a ripple of half-adders from AND2 and an XOR composed of primitives; registers are behavioural.

Decomposition:
- Shared include file holds:
  - State encoding constants S0..S4 (3'd0..3'd4).
  - State width 3.
  - The pattern constant 4'b1011, used for documentation and by the bench.
- One natural sub-module: dff_ar, a 1-bit D flip-flop with asynchronous active-high reset and enable. It is instantiated for the 3 state bits, the match register, the counter bits and cnt_sat.
- The half-adder chain stays inline in seq_detect_1011.

Test Plan:
- Reset mid-stream: drive 1,0,1 valid, assert rst asynchronously between edges -> outputs 0 immediately. After release, feed 1 -> no match; state restarted from S0.
- Basic and overlap: valid stream 1,0,1,1,0,1,1 -> match pulses exactly after bit 4 and bit 7; match_cnt = 1 then 2; never high in other cycles.
- Valid gaps: stream 1,(gap),0,(gap x3),1,1 with din_valid low in gaps -> single match pulse one cycle after last bit; match low during gaps; match_cnt = 1.
- Near-miss patterns: 1,1,1,0,0,1,0,1,1 -> exactly one match (after final bit); stream 1,0,0,1,1 -> zero matches.
- Saturation with CNT_W=2: repeat 1011 four times with overlap stream 1,0,1,1,0,1,1,0,1,1,0,1,1 -> match_cnt 1,2,3,3; cnt_sat rises with 3rd match; 4th match still pulses match.
- clr priority: mid-pattern "101" then clr=1 with din_valid=1, din=1 -> no match, match_cnt = 0, cnt_sat = 0. Following 1,0,1,1 -> match_cnt = 1.
